fifo_transmitter: RTL and testbench

- Transmit-side byte buffer for the UART path: producers (ALU/interface logic) push bytes; the block drains them one at a time into the UART transmitter.
- Uses an o_tx_start / i_tx_done handshake to the UART transmitter.
- Counterpart of the receive FIFO: circular buffer plus a small launch FSM that serialises back-to-back transmissions.

---
 rtl/fifo_transmitter.sv | 141 ++++++++++++++
 tb/tb_fifo_transmitter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_transmitter.sv
// Transmit byte FIFO with a two-state launch FSM feeding a UART transmitter.
// Define FIFO_TX_OVERFLOW_EN to build the sticky overflow flag; otherwise o_overflow is tied low.
module fifo_transmitter #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_wr_en,
   input  logic [DATA_WIDTH-1:0]         i_wr_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_tx_start,
   output logic [DATA_WIDTH-1:0]         o_tx_data,
   input  logic                          i_tx_done,
   output logic                          o_busy,
   output logic                          o_overflow
);

   // state | meaning
   // IDLE  | no frame in flight; launches the head entry whenever count != 0
   // BUSY  | frame in flight; waits for i_tx_done outside the start cycle
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   state_t                state_q, state_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  tx_start_q, tx_start_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = i_wr_en && !full;

   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               tx_data_d  = mem[rd_ptr_q];
               rd_ptr_d   = rd_ptr_q + AW'(1);
               tx_start_d = 1'b1;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // done is only meaningful once the start pulse has been seen by the UART
            if (i_tx_done && !tx_start_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr_q] <= i_wr_data;
      end
   end

`ifdef FIFO_TX_OVERFLOW_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q | (i_wr_en & full);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign o_overflow = overflow_q;
`else
   assign o_overflow = 1'b0;
`endif

   assign o_full     = full;
   assign o_empty    = empty;
   assign o_count    = count_q;
   assign o_tx_start = tx_start_q;
   assign o_tx_data  = tx_data_q;
   assign o_busy     = (state_q == BUSY);

endmodule

// File: tb/tb_fifo_transmitter.sv
// Scoreboard bench for fifo_transmitter: accepted bytes are queued, each o_tx_start pops and compares.
module tb_fifo_transmitter;

   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int CNTW = $clog2(DEPTH) + 1;
`ifdef FIFO_TX_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic            wr_en;
   logic [DW-1:0]   wr_data;
   logic            full;
   logic            empty;
   logic [CNTW-1:0] count;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic            tx_done;
   logic            busy;
   logic            overflow;

   logic auto_done;
   logic man_done;
   assign tx_done = auto_done | man_done;

   fifo_transmitter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_wr_en    (wr_en),
      .i_wr_data  (wr_data),
      .o_full     (full),
      .o_empty    (empty),
      .o_count    (count),
      .o_tx_start (tx_start),
      .o_tx_data  (tx_data),
      .i_tx_done  (tx_done),
      .o_busy     (busy),
      .o_overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   logic [DW-1:0] sb_q[$];
   int  cyc            = 0;
   int  start_cnt      = 0;
   int  last_done_edge = -100;
   bit  prev_start     = 1'b0;
   bit  gap_chk        = 1'b0;
   bit  auto_en        = 1'b0;
   int  auto_dly       = 10;

   always @(posedge clk) cyc++;

   // monitor: every start pulse must match the scoreboard head and last exactly one cycle
   always @(negedge clk) begin
      if (tx_done) last_done_edge = cyc + 1;
      if (tx_start) begin
         check("start_1cyc", prev_start, 1'b0);
         check("sb_nonempty_at_start", (sb_q.size() != 0), 1'b1);
         if (sb_q.size() != 0) check("tx_data", tx_data, sb_q.pop_front());
         if (gap_chk) check("done_to_start_gap", cyc - last_done_edge, 1);
         start_cnt++;
      end
      prev_start = tx_start;
   end

   // UART model: pulse done auto_dly cycles after each start
   initial begin
      auto_done = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_en && tx_start) begin
            repeat (auto_dly) @(posedge clk);
            #1 auto_done = 1'b1;
            @(posedge clk);
            #1 auto_done = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] b, input bit accept);
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_en   = 1'b0;
      if (accept) sb_q.push_back(b);
   endtask

   task automatic wait_drained(input string tag, input int target_starts);
      int i;
      for (i = 0; i < 2000; i++) begin
         if (start_cnt >= target_starts && !busy && sb_q.size() == 0) break;
         tick();
      end
      check({tag, "_drain_in_time"}, (i < 2000), 1'b1);
   endtask

   initial begin
      int base;
      int s0;
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = '0;
      man_done = 1'b0;
      #3;
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_count", count, 0);
      check("rst_start", tx_start, 1'b0);
      check("rst_data", tx_data, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // single byte latency
      push(8'hA5, 1'b1);
      check("t1_count_after_push", count, 1);
      check("t1_no_start_yet", tx_start, 1'b0);
      tick();
      check("t1_count_after_launch", count, 0);
      check("t1_start", tx_start, 1'b1);
      check("t1_busy", busy, 1'b1);
      tick();
      check("t1_start_drop", tx_start, 1'b0);
      repeat (3) tick();
      check("t1_busy_hold", busy, 1'b1);
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      check("t1_idle_after_done", busy, 1'b0);
      check("t1_empty", empty, 1'b1);
      check("t1_starts", start_cnt, 1);

      // back-to-back frames with 1-cycle gap after done
      auto_en  = 1'b1;
      auto_dly = 10;
      base     = start_cnt;
      push(8'h01, 1'b1);
      push(8'h02, 1'b1);
      push(8'h03, 1'b1);
      for (int i = 0; i < 20 && start_cnt < base + 1; i++) tick();
      gap_chk = 1'b1;
      wait_drained("t2", base + 3);
      gap_chk = 1'b0;
      auto_en = 1'b0;
      check("t2_starts", start_cnt - base, 3);
      check("t2_empty", empty, 1'b1);

      // fill to full while the first frame stays in flight, then overflow
      for (int i = 0; i <= 16; i++) push(8'(i), 1'b1);
      check("t3_full", full, 1'b1);
      check("t3_count", count, 16);
      push(8'h11, 1'b0);
      check("t3_count_after_reject", count, 16);
      check("t3_overflow", overflow, OVF_EN);
      check("t3_busy", busy, 1'b1);

      // push at full spanning done and relaunch: both edges reject
      man_done = 1'b1;
      wr_en    = 1'b1;
      wr_data  = 8'h77;
      tick();
      man_done = 1'b0;
      check("t4_count_at_done", count, 16);
      check("t4_idle", busy, 1'b0);
      tick();
      wr_en    = 1'b0;
      auto_en  = 1'b1;
      auto_dly = 3;
      check("t4_count_after_pop", count, 15);
      check("t4_not_full", full, 1'b0);
      check("t4_start", tx_start, 1'b1);
      wait_drained("t4", 0);
      check("t4_empty", empty, 1'b1);

      // 40 bytes with continuous draining, wraps pointers twice
      base = start_cnt;
      for (int b = 0; b < 40; b += 12) begin
         for (int i = 0; i < 2000 && sb_q.size() > 4; i++) tick();
         for (int k = b; k < b + 12 && k < 40; k++) push(8'(8'h40 + k), 1'b1);
      end
      wait_drained("t5", base + 40);
      check("t5_starts", start_cnt - base, 40);
      auto_en = 1'b0;
      tick();

      // reset mid-frame with 5 queued
      for (int i = 0; i < 6; i++) push(8'(8'hC0 + i), 1'b1);
      tick();
      tick();
      check("t6_busy", busy, 1'b1);
      check("t6_count", count, 5);
      #2 rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_count", count, 0);
      check("t6_rst_empty", empty, 1'b1);
      check("t6_rst_start", tx_start, 1'b0);
      check("t6_rst_data", tx_data, 0);
      check("t6_rst_ovf", overflow, 1'b0);
      tick();
      rst_n = 1'b1;
      s0 = start_cnt;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      repeat (5) tick();
      check("t6_no_start", start_cnt, s0);
      check("t6_empty_end", empty, 1'b1);
      check("t6_idle_end", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
